alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer.sv | 115 +++++++++++
 tb/tb_alu_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Control front end for the 8-bit ALU: handshake intake, 4x8 register file, issue and write-back.
// Define ALU_SEQ_PIPE_EN to accept a new request during write-back (one request per 2 cycles).
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [1:0] req_src_a,
  input  logic [1:0] req_src_b,
  input  logic [1:0] req_dst,
  input  logic       ld_en,
  input  logic [1:0] ld_sel,
  input  logic [7:0] ld_data,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       flag_zero,
  output logic       flag_carry,
  output logic       alu_enable,
  output logic [2:0] alu_op,
  output logic [7:0] alu_in_a,
  output logic [7:0] alu_in_b,
  input  logic [7:0] alu_out,
  input  logic       alu_flag_carry
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WB    = 2'b10
  } state_t;

  state_t     state, next_state;
  logic [7:0] regs [4];
  logic [2:0] op_q;
  logic [1:0] src_a_q, src_b_q, dst_q;
  logic       accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // The unused 2'b11 encoding falls into the default arm and recovers to IDLE.
  always_comb begin
    next_state = IDLE;
    req_ready  = 1'b0;
    alu_enable = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        req_ready  = !ld_en;
        next_state = (req_valid && !ld_en) ? ISSUE : IDLE;
      end
      ISSUE: begin
        alu_enable = 1'b1;
        next_state = WB;
      end
      WB: begin
        done = 1'b1;
`ifdef ALU_SEQ_PIPE_EN
        req_ready  = 1'b1;
        next_state = req_valid ? ISSUE : IDLE;
`else
        next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= 3'd0;
      src_a_q <= 2'd0;
      src_b_q <= 2'd0;
      dst_q   <= 2'd0;
    end else if (accept) begin
      op_q    <= req_op;
      src_a_q <= req_src_a;
      src_b_q <= req_src_b;
      dst_q   <= req_dst;
    end
  end

  // Direct loads only land in IDLE; write-back owns the file in WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
    end else if (state == IDLE && ld_en) begin
      regs[ld_sel] <= ld_data;
    end else if (state == WB) begin
      regs[dst_q] <= alu_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else if (state == WB) begin
      flag_zero  <= (alu_out == 8'd0);
      flag_carry <= alu_flag_carry;
    end
  end

  assign rd_data  = regs[rd_sel];
  assign alu_op   = op_q;
  assign alu_in_a = regs[src_a_q];
  assign alu_in_b = regs[src_b_q];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU plus a transaction-level register/flag model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [2:0] req_op;
  logic [1:0] req_src_a, req_src_b, req_dst;
  logic       ld_en;
  logic [1:0] ld_sel, rd_sel;
  logic [7:0] ld_data, rd_data;
  logic       done, flag_zero, flag_carry, alu_enable;
  logic [2:0] alu_op;
  logic [7:0] alu_in_a, alu_in_b, alu_out;
  logic       alu_flag_carry;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_regs [4];
  logic       model_carry, model_zero;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src_a(req_src_a), .req_src_b(req_src_b), .req_dst(req_dst),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .done(done), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .alu_enable(alu_enable), .alu_op(alu_op), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_out(alu_out), .alu_flag_carry(alu_flag_carry)
  );

  // Returns {carry, result} using plain integer arithmetic on the op table.
  function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
    int s;
    case (op)
      3'd0: begin s = int'(a) + int'(b);              return {s > 255, 8'(s)}; end
      3'd1: begin s = int'(a) - int'(b);              return {s < 0, 8'(s)}; end
      3'd2: begin s = int'(a) + 1;                    return {s > 255, 8'(s)}; end
      3'd3: begin s = int'(a) - 1;                    return {s < 0, 8'(s)}; end
      3'd4: return {1'b0, a & b};
      3'd5: return {1'b0, a | b};
      3'd6: return {1'b0, a ^ b};
      default: begin s = int'(a) + int'(b) + int'(cin); return {s > 255, 8'(s)}; end
    endcase
  endfunction

  // Stand-in ALU: one-cycle registered result, carry register doubles as ADC carry-in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {alu_flag_carry, alu_out} <= 9'd0;
    else if (alu_enable) {alu_flag_carry, alu_out} <= alu_ref(alu_op, alu_in_a, alu_in_b, alu_flag_carry);
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reg(input logic [1:0] idx);
    rd_sel = idx;
    #1;
    checkOutput($sformatf("reg%0d", idx), {8'd0, rd_data}, {8'd0, model_regs[idx]});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_regs[i] = 8'd0;
    model_carry = 1'b0;
    model_zero  = 1'b0;
  endtask

  task automatic model_exec(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
    logic [8:0] r;
    r = alu_ref(op, model_regs[a], model_regs[b], model_carry);
    model_regs[d] = r[7:0];
    model_carry   = r[8];
    model_zero    = (r[7:0] == 8'd0);
  endtask

  task automatic load_reg(input logic [1:0] sel, input logic [7:0] data);
    ld_en = 1'b1; ld_sel = sel; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    model_regs[sel] = data;
  endtask

  // One full request from IDLE, with per-cycle timing checks and a final state comparison.
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] d, input bit ld_in_issue);
    req_op = op; req_src_a = a; req_src_b = b; req_dst = d; req_valid = 1'b1;
    #1;
    checkOutput("ready_idle", {15'd0, req_ready}, 16'd1);
    @(negedge clk);
    req_valid = 1'b0;
    if (ld_in_issue) begin
      ld_en = 1'b1; ld_sel = d; ld_data = ~model_regs[d];
    end
    #1;
    checkOutput("issue_enable", {15'd0, alu_enable}, 16'd1);
    checkOutput("issue_done", {15'd0, done}, 16'd0);
    checkOutput("issue_op", {13'd0, alu_op}, {13'd0, op});
    checkOutput("issue_a", {8'd0, alu_in_a}, {8'd0, model_regs[a]});
    checkOutput("issue_b", {8'd0, alu_in_b}, {8'd0, model_regs[b]});
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    checkOutput("wb_done", {15'd0, done}, 16'd1);
    checkOutput("wb_enable", {15'd0, alu_enable}, 16'd0);
    model_exec(op, a, b, d);
    @(negedge clk);
    check_reg(d);
    checkOutput("flag_zero", {15'd0, flag_zero}, {15'd0, model_zero});
    checkOutput("flag_carry", {15'd0, flag_carry}, {15'd0, model_carry});
    checkOutput("after_done", {15'd0, done}, 16'd0);
    checkOutput("ready_again", {15'd0, req_ready}, 16'd1);
  endtask

  initial begin
    int cyc, accepts;
    int done_at [$];
    bit acc_now;
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_src_a = 2'd0; req_src_b = 2'd0; req_dst = 2'd0;
    ld_en = 1'b0; ld_sel = 2'd0; ld_data = 8'd0; rd_sel = 2'd0;
    model_reset();
    #1;
    checkOutput("rst_ready", {15'd0, req_ready}, 16'd1);
    checkOutput("rst_outs", {12'd0, done, alu_enable, flag_zero, flag_carry}, 16'd0);
    checkOutput("rst_rd", {8'd0, rd_data}, 16'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ADD, no overflow.
    load_reg(2'd0, 8'h7F);
    load_reg(2'd1, 8'h01);
    applyStimulus(3'd0, 2'd0, 2'd1, 2'd2, 1'b0);
    checkOutput("add_r2", {8'd0, model_regs[2]}, 16'h0080);

    // ADD overflow to zero.
    load_reg(2'd0, 8'hFF);
    applyStimulus(3'd0, 2'd0, 2'd1, 2'd3, 1'b0);
    check_reg(2'd3);
    checkOutput("ovf_flags", {14'd0, flag_zero, flag_carry}, 16'd3);

    // SUB borrow feeding ADC.
    load_reg(2'd0, 8'h00);
    applyStimulus(3'd1, 2'd0, 2'd1, 2'd2, 1'b0);
    checkOutput("sub_flags", {8'd0, rd_data}, 16'h00FF);
    checkOutput("sub_carry", {15'd0, flag_carry}, 16'd1);
    load_reg(2'd0, 8'h01);
    applyStimulus(3'd7, 2'd0, 2'd1, 2'd0, 1'b0);
    checkOutput("adc_r0", {8'd0, rd_data}, 16'h0003);

    // Load and request together: the load wins, request goes next cycle; load in ISSUE ignored.
    req_op = 3'd5; req_src_a = 2'd0; req_src_b = 2'd3; req_dst = 2'd3; req_valid = 1'b1;
    ld_en = 1'b1; ld_sel = 2'd3; ld_data = 8'hAA;
    #1;
    checkOutput("ld_prio_ready", {15'd0, req_ready}, 16'd0);
    @(negedge clk);
    ld_en = 1'b0;
    model_regs[3] = 8'hAA;
    check_reg(2'd3);
    applyStimulus(3'd5, 2'd0, 2'd3, 2'd3, 1'b1);

    // Back-to-back: XOR r1 then INC r1, both held valid.
    req_op = 3'd6; req_src_a = 2'd1; req_src_b = 2'd1; req_dst = 2'd1; req_valid = 1'b1;
    cyc = 0; accepts = 0;
    while (done_at.size() < 2 && cyc < 30) begin
      #1;
      acc_now = req_valid && req_ready;
      @(negedge clk);
      cyc++;
      #1;
      if (done) done_at.push_back(cyc);
      if (acc_now) begin
        accepts++;
        if (accepts == 1) req_op = 3'd2;
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    if (done_at.size() < 2) begin
      checkOutput("b2b_timeout", 16'(done_at.size()), 16'd2);
    end else begin
`ifdef ALU_SEQ_PIPE_EN
      checkOutput("b2b_spacing", 16'(done_at[1] - done_at[0]), 16'd2);
`else
      checkOutput("b2b_spacing", 16'(done_at[1] - done_at[0]), 16'd3);
`endif
    end
    model_exec(3'd6, 2'd1, 2'd1, 2'd1);
    model_exec(3'd2, 2'd1, 2'd1, 2'd1);
    @(negedge clk);
    check_reg(2'd1);
    checkOutput("b2b_r1", {8'd0, model_regs[1]}, 16'd1);

    // Randomised requests with interleaved loads.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) load_reg(2'($urandom_range(0, 3)), 8'($urandom));
      applyStimulus(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of ISSUE drops the request.
    load_reg(2'd0, 8'h05);
    load_reg(2'd1, 8'h06);
    req_op = 3'd0; req_src_a = 2'd0; req_src_b = 2'd1; req_dst = 2'd2; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    checkOutput("mid_rst_outs", {12'd0, done, alu_enable, flag_zero, flag_carry}, 16'd0);
    checkOutput("mid_rst_ready", {15'd0, req_ready}, 16'd1);
    checkOutput("mid_rst_alu_a", {8'd0, alu_in_a}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) check_reg(2'(i));
    checkOutput("post_rst_done", {15'd0, done}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
